// File: rtl/regbank_8x32.sv
// -----------------------------------------------------------------------------
// regbank_8x32
//
// Eight-entry register bank written through a one-hot write-select bus that
// comes straight from the upstream 3-to-8 write-address decoder. It has two
// combinational read ports for the ALU operand path of a single-cycle datapath.
//
// A select with more than one bit set is treated as corrupt. The bank drops
// that write, flags it for one cycle and counts it. A per-entry "written since
// reset" mask is kept for debug.
//
// Parameters
//   WIDTH     : data width of each entry
//   ZERO_REG0 : 1 -> entry 0 reads as zero and ignores writes
//   BYPASS    : 1 -> a read of the entry being written this cycle returns wdata
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   we_sel   in   8-bit one-hot write select (all-zero = no write)
//   wdata    in   write data
//   raddr_a  in   read address, port A
//   raddr_b  in   read address, port B
//   rdata_a  out  read data, port A (combinational)
//   rdata_b  out  read data, port B (combinational)
//   written  out  bit i set once entry i has accepted a write since reset
//   sel_err  out  one-cycle pulse: the previous cycle's we_sel was multi-hot
//   err_cnt  out  saturating count of multi-hot select cycles
// -----------------------------------------------------------------------------
module regbank_8x32 #(
    parameter int WIDTH     = 32,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       we_sel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       raddr_a,
    input  logic [2:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [7:0]       written,
    output logic             sel_err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_class_e;

    // Classifies the select by its population count: zero, exactly one, or more.
    function automatic sel_class_e classify_sel(input logic [7:0] sel);
        logic [3:0] ones;
        ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'd0, sel[i]};
        end
        case (ones)
            4'd0:    classify_sel = SEL_NONE;
            4'd1:    classify_sel = SEL_ONE;
            default: classify_sel = SEL_MULTI;
        endcase
    endfunction

    // Returns one read port's value. A read of entry 0 is forced to zero when
    // that entry is hardwired. Otherwise a write landing this cycle is forwarded
    // when bypass is on, and the stored value is returned in every other case.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [2:0]            addr,
        input logic [7:0][WIDTH-1:0] mem,
        input logic [7:0]            wmask,
        input logic [WIDTH-1:0]      wd
    );
        if ((ZERO_REG0 != 0) && (addr == 3'd0)) begin
            read_port = {WIDTH{1'b0}};
        end else if ((BYPASS != 0) && wmask[addr]) begin
            read_port = wd;
        end else begin
            read_port = mem[addr];
        end
    endfunction

    logic [7:0][WIDTH-1:0] mem_q, mem_d;
    logic [7:0]            written_q, written_d;
    logic                  sel_err_q, sel_err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    sel_class_e            sel_class_s;
    logic                  multi_s;
    logic [7:0]            wr_mask_s;

    // Decides which entry, if any, really takes the write this cycle.
    always_comb begin
        sel_class_s = classify_sel(we_sel);
        multi_s     = (sel_class_s == SEL_MULTI);
        wr_mask_s   = 8'h00;
        // The rst_n term keeps a write from being forwarded during reset,
        // because reset discards that write anyway.
        if (rst_n && (sel_class_s == SEL_ONE)) begin
            wr_mask_s = we_sel;
        end else begin
            wr_mask_s = 8'h00;
        end
        if (ZERO_REG0 != 0) begin
            wr_mask_s[0] = 1'b0;
        end else begin
            wr_mask_s[0] = wr_mask_s[0];
        end
    end

    // Computes the next state of the entries, the written mask and the error tracking.
    always_comb begin
        mem_d     = mem_q;
        written_d = written_q | wr_mask_s;
        sel_err_d = multi_s;
        err_cnt_d = err_cnt_q;
        for (int i = 0; i < 8; i++) begin
            if (wr_mask_s[i]) begin
                mem_d[i] = wdata;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
        if (multi_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Holds the state registers, which are cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= {8{{WIDTH{1'b0}}}};
            written_q <= 8'h00;
            sel_err_q <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            mem_q     <= mem_d;
            written_q <= written_d;
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Drives the read ports combinationally, with no registers on the read path.
    always_comb begin
        rdata_a = read_port(raddr_a, mem_q, wr_mask_s, wdata);
        rdata_b = read_port(raddr_b, mem_q, wr_mask_s, wdata);
    end

    assign written = written_q;
    assign sel_err = sel_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_regbank_8x32.sv
// -----------------------------------------------------------------------------
// tb_regbank_8x32
//
// Directed test of regbank_8x32. Two copies of the bank share the same inputs:
// `dut` has bypass enabled and `dut_nb` has bypass disabled. Every expected
// value is written out by hand in the sequence below.
// -----------------------------------------------------------------------------
module tb_regbank_8x32;

    logic        clk;
    logic        rst_n;
    logic [7:0]  we_sel;
    logic [31:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;

    logic [31:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
    logic [7:0]  written, nb_written, err_cnt, nb_err_cnt;
    logic        sel_err, nb_sel_err;

    int checks = 0;
    int errors = 0;

    regbank_8x32 #(.WIDTH(32), .ZERO_REG0(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we_sel(we_sel), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .written(written), .sel_err(sel_err), .err_cnt(err_cnt)
    );

    regbank_8x32 #(.WIDTH(32), .ZERO_REG0(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we_sel(we_sel), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(nb_rdata_a), .rdata_b(nb_rdata_b),
        .written(nb_written), .sel_err(nb_sel_err), .err_cnt(nb_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for the rising edge, then step 1 time unit past it. Inputs are
    // driven and outputs sampled there, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b1;
        we_sel  = 8'h00;
        wdata   = 32'h0000_0000;
        raddr_a = 3'd0;
        raddr_b = 3'd0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_written", {24'd0, written}, 32'h0000_0000);
        chk("rst_errcnt", {24'd0, err_cnt}, 32'h0000_0000);
        chk("rst_selerr", {31'd0, sel_err}, 32'h0000_0000);
        rst_n = 1'b1;
        tick();

        // Put a value in entry 2 so the later reset has something to clear.
        we_sel = 8'h04; wdata = 32'hCAFE_0002; raddr_a = 3'd2; raddr_b = 3'd2;
        tick();
        we_sel = 8'h00;
        #1;
        chk("pre_rst_rd2", rdata_a, 32'hCAFE_0002);
        chk("pre_rst_written", {24'd0, written}, 32'h0000_0004);

        // Assert reset mid-cycle while a write of entry 2 is being presented.
        #2;
        we_sel = 8'h04; wdata = 32'hDEAD_BEEF; rst_n = 1'b0;
        #1;
        chk("rst_imm_rda", rdata_a, 32'h0000_0000);
        chk("rst_imm_rdb", rdata_b, 32'h0000_0000);
        chk("rst_imm_written", {24'd0, written}, 32'h0000_0000);
        chk("rst_imm_errcnt", {24'd0, err_cnt}, 32'h0000_0000);
        tick();
        chk("rst_hold_rda", rdata_a, 32'h0000_0000);
        we_sel = 8'h00;
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_rd2", rdata_a, 32'h0000_0000);
        chk("post_rst_written", {24'd0, written}, 32'h0000_0000);

        // Basic write and read.
        we_sel = 8'h02; wdata = 32'h1111_1111;
        tick();
        we_sel = 8'h80; wdata = 32'h2222_2222;
        tick();
        we_sel = 8'h00; raddr_a = 3'd1; raddr_b = 3'd7;
        #1;
        chk("basic_rda", rdata_a, 32'h1111_1111);
        chk("basic_rdb", rdata_b, 32'h2222_2222);
        chk("basic_written", {24'd0, written}, 32'h0000_0082);
        chk("basic_nb_rdb", nb_rdata_b, 32'h2222_2222);

        // Zero register.
        tick();
        we_sel = 8'h01; wdata = 32'hFFFF_FFFF; raddr_a = 3'd0;
        #1;
        chk("zero_same_rda", rdata_a, 32'h0000_0000);
        tick();
        we_sel = 8'h00;
        #1;
        chk("zero_next_rda", rdata_a, 32'h0000_0000);
        chk("zero_written", {24'd0, written}, 32'h0000_0082);
        chk("zero_selerr", {31'd0, sel_err}, 32'h0000_0000);

        // Bypass on and off: entry 3 first holds A5A5_A5A5.
        we_sel = 8'h08; wdata = 32'hA5A5_A5A5;
        tick();
        we_sel = 8'h08; wdata = 32'h5A5A_5A5A; raddr_a = 3'd3; raddr_b = 3'd3;
        #1;
        chk("byp_rda", rdata_a, 32'h5A5A_5A5A);
        chk("byp_rdb", rdata_b, 32'h5A5A_5A5A);
        chk("nobyp_rda", nb_rdata_a, 32'hA5A5_A5A5);
        chk("nobyp_rdb", nb_rdata_b, 32'hA5A5_A5A5);
        tick();
        we_sel = 8'h00; wdata = 32'h0000_0000;
        #1;
        chk("nobyp_next_rda", nb_rdata_a, 32'h5A5A_5A5A);
        chk("nobyp_next_rdb", nb_rdata_b, 32'h5A5A_5A5A);
        chk("byp_next_rda", rdata_a, 32'h5A5A_5A5A);

        // A multi-hot select for one cycle.
        tick();
        we_sel = 8'h18; wdata = 32'h1234_5678; raddr_a = 3'd3; raddr_b = 3'd4;
        #1;
        chk("multi_nobyp_rda", rdata_a, 32'h5A5A_5A5A);
        chk("multi_nobyp_rdb", rdata_b, 32'h0000_0000);
        chk("multi_selerr_pre", {31'd0, sel_err}, 32'h0000_0000);
        tick();
        we_sel = 8'h00;
        #1;
        chk("multi_selerr", {31'd0, sel_err}, 32'h0000_0001);
        chk("multi_errcnt", {24'd0, err_cnt}, 32'h0000_0001);
        chk("multi_rd3", rdata_a, 32'h5A5A_5A5A);
        chk("multi_rd4", rdata_b, 32'h0000_0000);
        chk("multi_written", {24'd0, written}, 32'h0000_008A);
        tick();
        chk("multi_selerr_drop", {31'd0, sel_err}, 32'h0000_0000);
        chk("multi_errcnt_hold", {24'd0, err_cnt}, 32'h0000_0001);

        // Hold 8'hFF for 300 cycles to reach saturation.
        we_sel = 8'hFF; wdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("sat_selerr", {31'd0, sel_err}, 32'h0000_0001);
            chk("sat_errcnt", {24'd0, err_cnt}, (i + 2 > 255) ? 32'd255 : 32'(i + 2));
        end
        we_sel = 8'h00;
        #1;
        chk("sat_selerr_hold", {31'd0, sel_err}, 32'h0000_0001);
        chk("sat_rd3", rdata_a, 32'h5A5A_5A5A);
        tick();
        chk("sat_selerr_drop", {31'd0, sel_err}, 32'h0000_0000);
        chk("sat_errcnt_final", {24'd0, err_cnt}, 32'h0000_00FF);
        chk("sat_written", {24'd0, written}, 32'h0000_008A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_8x32.md
# regbank_8x32

Eight-entry register bank written through a one-hot write-select bus. The bus is produced directly by the 3-to-8 write-address decoder upstream, with its enable tied to the register-write control. Two combinational read ports feed the ALU operand path of the single-cycle datapath. The block also guards against corrupt (multi-hot) selects and keeps a per-entry "written since reset" mask for debug and verification.

## Interface
Parameters:
- WIDTH, 32, data width of each entry
- ZERO_REG0, 1, when 1 entry 0 is hardwired to zero and ignores writes
- BYPASS, 1, when 1 a read of the entry being written this cycle returns wdata

Ports:
- clk  in  1  single clock, rising-edge active
- rst_n  in  1  reset, asynchronous, active-low
- we_sel  in  8  one-hot write select from decoder; all-zero = no write
- wdata  in  WIDTH  write data
- raddr_a  in  3  read address, port A
- raddr_b  in  3  read address, port B
- rdata_a  out  WIDTH  read data, port A (combinational)
- rdata_b  out  WIDTH  read data, port B (combinational)
- written  out  8  bit i set once entry i has accepted a write since reset
- sel_err  out  1  registered one-cycle pulse: previous cycle's we_sel was multi-hot
- err_cnt  out  8  saturating count of multi-hot select cycles

## Operation
- Select classification each cycle: NONE (we_sel == 0), ONE (exactly one bit set), MULTI (two or more bits set).
- ONE: on the rising clk edge, entry i (the set bit) takes wdata and written[i] is set.
- ONE exception: if i == 0 and ZERO_REG0 = 1, the entry stays 0 and written[0] stays 0.
- NONE: no state change.
- MULTI: the write is suppressed entirely, with no entry and no written bit changed. sel_err goes 1 for the next cycle only. err_cnt increments and saturates at 255 with no wrap.
- Reads: rdata_x = entry[raddr_x]. When ZERO_REG0 = 1, raddr_x == 0 always returns 0.
- Bypass (BYPASS = 1): if the current we_sel is ONE with bit k, raddr_x == k, and k is writable, rdata_x = wdata in the same cycle.
- Bypass is not applied for MULTI, NONE, or a k == 0 write with ZERO_REG0 = 1.
- BYPASS = 0: reads return the stored value until after the edge.
- Both ports may read the same address, and each may read the address being written; both ports then see the same value.

## Timing
- Reset (rst_n low, async): all entries 0, written = 0, sel_err = 0, err_cnt = 0.
- Reset takes effect immediately without a clock and holds while low.
- Reset asserted mid-operation discards any write in that cycle.
- The first write is accepted on the first rising edge where rst_n is high and was already high before the edge.
- Write latency: 1 edge. Stored value is visible on a non-bypassed read in the cycle after the edge.
- Bypassed read latency: 0 cycles (combinational from wdata/we_sel).
- sel_err: asserted the cycle after the MULTI sample and cleared the following cycle unless MULTI repeats.
- Consecutive MULTI cycles hold sel_err high continuously; err_cnt increments every such cycle.
- Read ports have no registers; the path is raddr to rdata (plus the bypass mux) and must settle within the single-cycle datapath budget.
- No handshake: the upstream decoder output is sampled every edge.

## Test plan
- Reset: drive rst_n low mid-cycle with we_sel = 8'h04, wdata = 32'hDEAD_BEEF -> all reads 0, written = 8'h00, err_cnt = 0 immediately. Entry 2 stays 0 after release.
- Basic write/read: write 32'h1111_1111 via we_sel = 8'h02 and 32'h2222_2222 via 8'h80; read raddr_a = 1, raddr_b = 7 -> 32'h1111_1111 / 32'h2222_2222, written = 8'h82.
- Zero register: we_sel = 8'h01, wdata = 32'hFFFF_FFFF -> rdata_a at raddr 0 is 0 in the same and next cycle; written[0] = 0; sel_err = 0.
- Bypass: entry 3 holds 32'hA5A5_A5A5; in one cycle we_sel = 8'h08, wdata = 32'h5A5A_5A5A, raddr_a = raddr_b = 3 -> both ports 32'h5A5A_5A5A that cycle.
- Bypass disabled: with BYPASS = 0, the same stimulus -> both ports 32'hA5A5_A5A5 that cycle and 32'h5A5A_5A5A the next.
- Multi-hot: we_sel = 8'h18 for one cycle with wdata = 32'h1234_5678 -> entries 3 and 4 unchanged, sel_err high exactly one cycle, err_cnt = 1, no bypass on reads of 3 or 4.
- Saturation: hold we_sel = 8'hFF for 300 cycles -> err_cnt stops at 255, sel_err stays high throughout and drops one cycle after we_sel returns to 8'h00.
